exmem_stage_reg: RTL and testbench

EXMEM_STAGE_REG -- requirements
Module: exmem_stage_reg

---
 rtl/exmem_stage_reg.sv | 120 ++++++++++++
 tb/tb_exmem_stage_reg.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exmem_stage_reg.sv
`default_nettype none
// =============================================================================
// exmem_stage_reg : STAGES-deep EX/MEM register with stall, flush, forwarding
// Revision 1.0
// =============================================================================
module exmem_stage_reg #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int STAGES = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ex_valid,
   input  logic [DATA_W-1:0]            ex_alu_out,
   input  logic [DATA_W-1:0]            ex_write_data,
   input  logic [REG_W-1:0]             ex_write_reg,
   input  logic                         ex_reg_write,
   input  logic                         ex_mem_to_reg,
   input  logic                         ex_mem_write,
   input  logic                         stall,
   input  logic                         flush,
   input  logic [REG_W-1:0]             fwd_src_reg,
   output logic                         mem_valid,
   output logic [DATA_W-1:0]            mem_alu_out,
   output logic [DATA_W-1:0]            mem_write_data,
   output logic [REG_W-1:0]             mem_write_reg,
   output logic                         mem_reg_write,
   output logic                         mem_mem_to_reg,
   output logic                         mem_mem_write,
   output logic                         fwd_hit,
   output logic [DATA_W-1:0]            fwd_data,
   output logic [$clog2(STAGES+1)-1:0]  occupancy
);

   localparam int c_OCC_W = $clog2(STAGES+1);

   logic              r_sliceValid     [STAGES];
   logic [DATA_W-1:0] r_sliceAluOut    [STAGES];
   logic [DATA_W-1:0] r_sliceWriteData [STAGES];
   logic [REG_W-1:0]  r_sliceWriteReg  [STAGES];
   logic              r_sliceRegWrite  [STAGES];
   logic              r_sliceMemToReg  [STAGES];
   logic              r_sliceMemWrite  [STAGES];

   logic              w_fwdHit;
   logic [DATA_W-1:0] w_fwdData;
   logic [c_OCC_W-1:0] w_occupancy;

   // Slice 0 is youngest; a flush kills valid/control but leaves data fields untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            r_sliceValid[k]     <= 1'b0;
            r_sliceAluOut[k]    <= '0;
            r_sliceWriteData[k] <= '0;
            r_sliceWriteReg[k]  <= '0;
            r_sliceRegWrite[k]  <= 1'b0;
            r_sliceMemToReg[k]  <= 1'b0;
            r_sliceMemWrite[k]  <= 1'b0;
         end
      end else if (flush) begin
         for (int k = 0; k < STAGES; k++) begin
            r_sliceValid[k]    <= 1'b0;
            r_sliceRegWrite[k] <= 1'b0;
            r_sliceMemToReg[k] <= 1'b0;
            r_sliceMemWrite[k] <= 1'b0;
         end
      end else if (!stall) begin
         r_sliceValid[0]     <= ex_valid;
         r_sliceAluOut[0]    <= ex_alu_out;
         r_sliceWriteData[0] <= ex_write_data;
         r_sliceWriteReg[0]  <= ex_write_reg;
         r_sliceRegWrite[0]  <= ex_valid & ex_reg_write & (ex_write_reg != '0);
         r_sliceMemToReg[0]  <= ex_valid & ex_mem_to_reg;
         r_sliceMemWrite[0]  <= ex_valid & ex_mem_write;
         for (int k = 1; k < STAGES; k++) begin
            r_sliceValid[k]     <= r_sliceValid[k-1];
            r_sliceAluOut[k]    <= r_sliceAluOut[k-1];
            r_sliceWriteData[k] <= r_sliceWriteData[k-1];
            r_sliceWriteReg[k]  <= r_sliceWriteReg[k-1];
            r_sliceRegWrite[k]  <= r_sliceRegWrite[k-1];
            r_sliceMemToReg[k]  <= r_sliceMemToReg[k-1];
            r_sliceMemWrite[k]  <= r_sliceMemWrite[k-1];
         end
      end
   end

   // Scan oldest to youngest so the youngest matching slice wins.
   always_comb begin
      w_fwdHit  = 1'b0;
      w_fwdData = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         if (r_sliceValid[k] && r_sliceRegWrite[k] &&
             (r_sliceWriteReg[k] == fwd_src_reg) && (fwd_src_reg != '0)) begin
            w_fwdHit  = 1'b1;
            w_fwdData = r_sliceAluOut[k];
         end
      end
   end

   always_comb begin
      w_occupancy = '0;
      for (int k = 0; k < STAGES; k++) begin
         w_occupancy = w_occupancy + c_OCC_W'(r_sliceValid[k]);
      end
   end

   assign mem_valid      = r_sliceValid[STAGES-1];
   assign mem_alu_out    = r_sliceAluOut[STAGES-1];
   assign mem_write_data = r_sliceWriteData[STAGES-1];
   assign mem_write_reg  = r_sliceWriteReg[STAGES-1];
   assign mem_reg_write  = r_sliceRegWrite[STAGES-1];
   assign mem_mem_to_reg = r_sliceMemToReg[STAGES-1];
   assign mem_mem_write  = r_sliceMemWrite[STAGES-1];
   assign fwd_hit        = w_fwdHit;
   assign fwd_data       = w_fwdData;
   assign occupancy      = w_occupancy;

endmodule
`default_nettype wire

// File: tb/tb_exmem_stage_reg.sv
`default_nettype none
// =============================================================================
// tb_exmem_stage_reg : bench for STAGES=1,2,3 instances against a pipeline model
// Revision 1.0
// =============================================================================
module tb_exmem_stage_reg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid;
   logic [31:0] ex_alu_out;
   logic [31:0] ex_write_data;
   logic [4:0]  ex_write_reg;
   logic        ex_reg_write;
   logic        ex_mem_to_reg;
   logic        ex_mem_write;
   logic        stall;
   logic        flush;
   logic [4:0]  fwd_src_reg;

   logic        oValid [3];
   logic [31:0] oAlu   [3];
   logic [31:0] oWd    [3];
   logic [4:0]  oWr    [3];
   logic        oRw    [3];
   logic        oM2r   [3];
   logic        oMw    [3];
   logic        oHit   [3];
   logic [31:0] oFd    [3];
   logic [3:0]  oOcc   [3];

   int nErr    = 0;
   int nChecks = 0;
   bit checkOn = 1'b0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [$clog2(g+2)-1:0] occL;
      exmem_stage_reg #(.DATA_W(32), .REG_W(5), .STAGES(g+1)) u_dut (
         .clk            (clk),
         .rst_n          (rst_n),
         .ex_valid       (ex_valid),
         .ex_alu_out     (ex_alu_out),
         .ex_write_data  (ex_write_data),
         .ex_write_reg   (ex_write_reg),
         .ex_reg_write   (ex_reg_write),
         .ex_mem_to_reg  (ex_mem_to_reg),
         .ex_mem_write   (ex_mem_write),
         .stall          (stall),
         .flush          (flush),
         .fwd_src_reg    (fwd_src_reg),
         .mem_valid      (oValid[g]),
         .mem_alu_out    (oAlu[g]),
         .mem_write_data (oWd[g]),
         .mem_write_reg  (oWr[g]),
         .mem_reg_write  (oRw[g]),
         .mem_mem_to_reg (oM2r[g]),
         .mem_mem_write  (oMw[g]),
         .fwd_hit        (oHit[g]),
         .fwd_data       (oFd[g]),
         .occupancy      (occL)
      );
      assign oOcc[g] = 4'(occL);
   end

   // Model: each instance is a list of in-flight instructions, entry 0 youngest.
   typedef struct {
      bit          v;
      logic [31:0] alu;
      logic [31:0] wd;
      logic [4:0]  wr;
      bit          rw;
      bit          m2r;
      bit          mw;
   } ent_t;

   ent_t pipe [3][4];

   task automatic modelReset();
      for (int i = 0; i < 3; i++)
         for (int k = 0; k < 4; k++)
            pipe[i][k] = '{v:0, alu:0, wd:0, wr:0, rw:0, m2r:0, mw:0};
   endtask

   task automatic modelStep();
      ent_t e;
      e.v   = ex_valid;
      e.alu = ex_alu_out;
      e.wd  = ex_write_data;
      e.wr  = ex_write_reg;
      e.rw  = ex_valid && ex_reg_write && (ex_write_reg != 0);
      e.m2r = ex_valid && ex_mem_to_reg;
      e.mw  = ex_valid && ex_mem_write;
      for (int i = 0; i < 3; i++) begin
         if (flush) begin
            for (int k = 0; k <= i; k++) begin
               pipe[i][k].v = 0; pipe[i][k].rw = 0;
               pipe[i][k].m2r = 0; pipe[i][k].mw = 0;
            end
         end else if (!stall) begin
            for (int k = i; k >= 1; k--) pipe[i][k] = pipe[i][k-1];
            pipe[i][0] = e;
         end
      end
   endtask

   function automatic logic [109:0] expOut(int i);
      ent_t        last;
      bit          hit = 0;
      logic [31:0] fd  = 0;
      int          occ = 0;
      last = pipe[i][i];
      for (int k = 0; k <= i; k++) begin
         if (pipe[i][k].v) occ++;
         if (!hit && pipe[i][k].v && pipe[i][k].rw && pipe[i][k].wr == fwd_src_reg && fwd_src_reg != 0) begin
            hit = 1;
            fd  = pipe[i][k].alu;
         end
      end
      return {last.v, last.alu, last.wd, last.wr, last.rw, last.m2r, last.mw, hit, fd, 4'(occ)};
   endfunction

   always @(negedge clk) begin
      if (checkOn) begin
         for (int i = 0; i < 3; i++) begin
            logic [109:0] act, exp;
            exp = expOut(i);
            act = {oValid[i], oAlu[i], oWd[i], oWr[i], oRw[i], oM2r[i], oMw[i], oHit[i], oFd[i], oOcc[i]};
            nChecks++;
            if (act !== exp) begin
               nErr++;
               $display("FAIL cycle_compare stages=%0d t=%0t got=%h want=%h", i+1, $time, act, exp);
            end
         end
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic setIn(bit v, logic [31:0] alu, logic [4:0] wr, bit rw, bit st = 0, bit fl = 0);
      ex_valid      = v;
      ex_alu_out    = alu;
      ex_write_data = $urandom;
      ex_write_reg  = wr;
      ex_reg_write  = rw;
      ex_mem_to_reg = 1'($urandom);
      ex_mem_write  = 1'($urandom);
      stall         = st;
      flush         = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) modelStep();
      #1;
   endtask

   task automatic asyncReset();
      #2 rst_n = 1'b0;
      modelReset();
      #1;
   endtask

   task automatic release_();
      @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      fwd_src_reg = 5'd0;
      setIn(0, 32'h0, 5'd0, 0);
      #1 rst_n = 1'b0;
      modelReset();
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("reset_mem_valid", 32'(oValid[i]), 32'h0);
         chk("reset_occupancy", 32'(oOcc[i]), 32'h0);
      end
      checkOn = 1'b1;
      tick();
      tick();
      release_();

      // Two-slice latency
      setIn(1, 32'h1234, 5'd7, 1); tick();
      chk("s2_not_yet_valid", 32'(oValid[1]), 32'h0);
      setIn(1, 32'h5678, 5'd9, 1); tick();
      chk("s2_latency_alu", oAlu[1], 32'h1234);
      chk("s2_latency_wr", 32'(oWr[1]), 32'd7);
      chk("s2_latency_rw", 32'(oRw[1]), 32'h1);
      chk("s2_latency_valid", 32'(oValid[1]), 32'h1);
      chk("s2_occupancy", 32'(oOcc[1]), 32'd2);

      // Stall hold on single slice
      setIn(1, 32'hAA, 5'd3, 1); tick();
      chk("s1_loaded", oAlu[0], 32'hAA);
      for (int n = 0; n < 3; n++) begin
         setIn(1, 32'hBB, 5'd3, 1, 1, 0); tick();
         chk("s1_stall_hold", oAlu[0], 32'hAA);
      end
      setIn(1, 32'hBB, 5'd3, 1, 0, 0); tick();
      chk("s1_after_stall", oAlu[0], 32'hBB);

      // Flush overrides stall on a full three-slice pipe
      for (int n = 0; n < 3; n++) begin
         setIn(1, 32'h100 + n, 5'd4, 1); tick();
      end
      chk("s3_full", 32'(oOcc[2]), 32'd3);
      setIn(1, 32'h200, 5'd4, 1, 1, 1); tick();
      chk("s3_flush_valid", 32'(oValid[2]), 32'h0);
      chk("s3_flush_ctrl", {29'd0, oRw[2], oM2r[2], oMw[2]}, 32'h0);
      chk("s3_flush_occ", 32'(oOcc[2]), 32'h0);

      // Register zero never writes or forwards
      setIn(1, 32'h77, 5'd0, 1); tick();
      chk("r0_reg_write", 32'(oRw[0]), 32'h0);
      chk("r0_valid", 32'(oValid[0]), 32'h1);
      chk("r0_fwd_hit", 32'(oHit[0]), 32'h0);

      // Youngest-match forwarding
      fwd_src_reg = 5'd5;
      setIn(1, 32'h11, 5'd5, 1); tick();
      setIn(1, 32'h22, 5'd5, 1); tick();
      chk("fwd_young_hit", 32'(oHit[1]), 32'h1);
      chk("fwd_young_data", oFd[1], 32'h22);
      setIn(1, 32'h11, 5'd5, 1); tick();
      setIn(0, 32'h99, 5'd5, 1); tick();
      chk("fwd_bubble_hit", 32'(oHit[1]), 32'h1);
      chk("fwd_bubble_data", oFd[1], 32'h11);
      fwd_src_reg = 5'd0;

      // Mid-cycle async reset with two in flight
      setIn(1, 32'h3333, 5'd6, 1); tick();
      setIn(1, 32'h4444, 5'd6, 1); tick();
      chk("pre_reset_occ", 32'(oOcc[1]), 32'd2);
      asyncReset();
      chk("async_valid", 32'(oValid[1]), 32'h0);
      chk("async_alu", oAlu[1], 32'h0);
      chk("async_occ", 32'(oOcc[1]), 32'h0);
      chk("async_fwd", {31'd0, oHit[1]} | oFd[1], 32'h0);
      release_();
      setIn(1, 32'hCAFE, 5'd3, 1); tick();
      chk("post_reset_lat1", 32'(oValid[1]), 32'h0);
      setIn(0, 32'h0, 5'd0, 0); tick();
      chk("post_reset_lat2_valid", 32'(oValid[1]), 32'h1);
      chk("post_reset_lat2_alu", oAlu[1], 32'hCAFE);

      // Randomised traffic
      for (int n = 0; n < 2000; n++) begin
         setIn(($urandom_range(0, 9) < 7), $urandom, 5'($urandom_range(0, 7)), 1'($urandom),
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
         fwd_src_reg = 5'($urandom_range(0, 7));
         tick();
         if ($urandom_range(0, 199) == 0) begin
            asyncReset();
            release_();
         end
      end

      @(negedge clk);
      #1;
      checkOn = 1'b0;
      $display("Result: errors=%0d of %0d checks", nErr, nChecks);
      $finish;
   end

endmodule
`default_nettype wire
